// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared types and ISA constants for the register-file sequencer
//
// Purpose: state enumeration, opcode/op field constants and writeback-select
// encodings used by regfile_seq_decode and regfile_seq_ctrl.
// Ports: none (package).
// Optional feature macro: REGFILE_SEQ_ILLEGAL_TRAP_EN (uses ST_TRAP).
package regfile_seq_pkg;

   typedef enum logic [2:0] {
      ST_WAIT      = 3'd0,
      ST_DECODE    = 3'd1,
      ST_WRITE_IMM = 3'd2,
      ST_GET_A     = 3'd3,
      ST_GET_B     = 3'd4,
      ST_ALU       = 3'd5,
      ST_WRITE_REG = 3'd6,
      ST_TRAP      = 3'd7
   } state_e;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] MOV_IMM = 2'b10;
   localparam logic [1:0] MOV_REG = 2'b00;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_CMP = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;

   localparam logic [1:0] VSEL_C   = 2'b00;
   localparam logic [1:0] VSEL_IMM = 2'b01;

endpackage

// File: rtl/regfile_seq_decode.sv
// rtl/regfile_seq_decode.sv - combinational instruction-register field decoder
//
// Purpose: slices the instruction register into its fields, sign-extends the
// 8-bit immediate and classifies the instruction.
// Ports:
//   ir_i        instruction register contents
//   rn_o/rd_o/rm_o  register index fields IR[10:8] / IR[7:5] / IR[2:0]
//   sh_o        shifter op IR[4:3]
//   op_o        op field IR[12:11]
//   sximm8_o    IR[7:0] sign-extended to DW
//   mov_imm_o, mov_reg_o, alu_o, mvn_o, cmp_o  instruction-class flags
module regfile_seq_decode
   import regfile_seq_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [DW-1:0] ir_i,
   output logic [2:0]    rn_o,
   output logic [2:0]    rd_o,
   output logic [2:0]    rm_o,
   output logic [1:0]    sh_o,
   output logic [1:0]    op_o,
   output logic [DW-1:0] sximm8_o,
   output logic          mov_imm_o,
   output logic          mov_reg_o,
   output logic          alu_o,
   output logic          mvn_o,
   output logic          cmp_o
);

   logic [2:0] opcode;

   assign opcode   = ir_i[15:13];
   assign op_o     = ir_i[12:11];
   assign rn_o     = ir_i[10:8];
   assign rd_o     = ir_i[7:5];
   assign sh_o     = ir_i[4:3];
   assign rm_o     = ir_i[2:0];
   assign sximm8_o = {{(DW-8){ir_i[7]}}, ir_i[7:0]};

   assign mov_imm_o = (opcode == OPC_MOV) && (op_o == MOV_IMM);
   assign mov_reg_o = (opcode == OPC_MOV) && (op_o == MOV_REG);
   assign alu_o     = (opcode == OPC_ALU);
   assign mvn_o     = alu_o && (op_o == ALU_MVN);
   assign cmp_o     = alu_o && (op_o == ALU_CMP);

endmodule

// File: rtl/regfile_seq_ctrl.sv
// rtl/regfile_seq_ctrl.sv - Moore FSM sequencing register file and datapath per instruction
//
// Purpose: holds the instruction register, steps through WAIT/DECODE/operand
// fetch/ALU/writeback states and drives register-file and datapath strobes.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load, in          capture in into IR while w=1
//   s, w              start request / idle-ready flag
//   readnum, writenum, write        register-file controls
//   loada, loadb, loadc, loads      datapath load strobes
//   asel, bsel, vsel, shift, aluop  datapath selects
//   sximm8            sign-extended IR[7:0]
//   err               illegal-opcode trap flag (only with REGFILE_SEQ_ILLEGAL_TRAP_EN)
// Optional feature macro: REGFILE_SEQ_ILLEGAL_TRAP_EN.
module regfile_seq_ctrl
   import regfile_seq_pkg::*;
#(
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [DW-1:0] in,
   input  logic          s,
   output logic          w,
   output logic [RW-1:0] readnum,
   output logic [RW-1:0] writenum,
   output logic          write,
   output logic          loada,
   output logic          loadb,
   output logic          loadc,
   output logic          loads,
   output logic          asel,
   output logic          bsel,
   output logic [1:0]    vsel,
   output logic [1:0]    shift,
   output logic [1:0]    aluop,
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
   output logic          err,
`endif
   output logic [DW-1:0] sximm8
);

   state_e        state_q, state_d;
   logic [DW-1:0] ir_q;

   logic          w_q, write_q, loada_q, loadb_q, loadc_q, loads_q, asel_q;
   logic [1:0]    vsel_q;
   logic [RW-1:0] readnum_q, writenum_q;

   logic [2:0]    rn, rd, rm;
   logic [1:0]    sh, op;
   logic          mov_imm, mov_reg, is_alu, is_mvn, is_cmp;

   regfile_seq_decode #(.DW(DW)) u_decode (
      .ir_i      (ir_q),
      .rn_o      (rn),
      .rd_o      (rd),
      .rm_o      (rm),
      .sh_o      (sh),
      .op_o      (op),
      .sximm8_o  (sximm8),
      .mov_imm_o (mov_imm),
      .mov_reg_o (mov_reg),
      .alu_o     (is_alu),
      .mvn_o     (is_mvn),
      .cmp_o     (is_cmp)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_WAIT:      if (s) state_d = ST_DECODE;
         ST_DECODE: begin
            if (mov_imm)                state_d = ST_WRITE_IMM;
            else if (mov_reg || is_mvn) state_d = ST_GET_B;
            else if (is_alu)            state_d = ST_GET_A;
            else begin
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
               state_d = ST_TRAP;
`else
               state_d = ST_WAIT;
`endif
            end
         end
         ST_WRITE_IMM: state_d = ST_WAIT;
         ST_GET_A:     state_d = ST_GET_B;
         ST_GET_B:     state_d = ST_ALU;
         ST_ALU:       state_d = is_cmp ? ST_WAIT : ST_WRITE_REG;
         ST_WRITE_REG: state_d = ST_WAIT;
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
         ST_TRAP:      state_d = ST_TRAP;
`else
         ST_TRAP:      state_d = ST_WAIT;
`endif
         default:      state_d = ST_WAIT;
      endcase
   end

   // Outputs are registered from the next state so each strobe is high for
   // exactly the cycle the FSM sits in the corresponding state. IR cannot
   // change outside WAIT, so its fields are stable whenever they are used.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_WAIT;
         ir_q       <= '0;
         w_q        <= 1'b1;
         write_q    <= 1'b0;
         loada_q    <= 1'b0;
         loadb_q    <= 1'b0;
         loadc_q    <= 1'b0;
         loads_q    <= 1'b0;
         asel_q     <= 1'b0;
         vsel_q     <= VSEL_C;
         readnum_q  <= '0;
         writenum_q <= '0;
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
         err        <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (load && w_q) ir_q <= in;
         w_q     <= (state_d == ST_WAIT);
         write_q <= (state_d == ST_WRITE_IMM) || (state_d == ST_WRITE_REG);
         loada_q <= (state_d == ST_GET_A);
         loadb_q <= (state_d == ST_GET_B);
         loadc_q <= (state_d == ST_ALU);
         loads_q <= (state_d == ST_ALU) && is_cmp;
         // A forced to zero turns the ALU into a pass-through for MOV reg / MVN.
         asel_q  <= (state_d == ST_ALU) && (mov_reg || is_mvn);
         vsel_q  <= (state_d == ST_WRITE_IMM) ? VSEL_IMM : VSEL_C;
         if (state_d == ST_GET_A)      readnum_q <= rn;
         else if (state_d == ST_GET_B) readnum_q <= rm;
         else                          readnum_q <= '0;
         if (state_d == ST_WRITE_IMM)      writenum_q <= rn;
         else if (state_d == ST_WRITE_REG) writenum_q <= rd;
         else                              writenum_q <= '0;
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
         err     <= (state_d == ST_TRAP);
`endif
      end
   end

   assign w        = w_q;
   assign write    = write_q;
   assign loada    = loada_q;
   assign loadb    = loadb_q;
   assign loadc    = loadc_q;
   assign loads    = loads_q;
   assign asel     = asel_q;
   assign bsel     = 1'b0;
   assign vsel     = vsel_q;
   assign readnum  = readnum_q;
   assign writenum = writenum_q;
   assign shift    = sh;
   // MOV reg reuses the ALU as an adder so that C = 0 + shifted Rm.
   assign aluop    = mov_reg ? ALU_ADD : op;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb/tb_regfile_seq_ctrl.sv - scoreboard testbench for regfile_seq_ctrl
module tb_regfile_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset, load, s;
   logic [15:0] in;
   logic        w, write, loada, loadb, loadc, loads, asel, bsel;
   logic [2:0]  readnum, writenum;
   logic [1:0]  vsel, shift, aluop;
   logic [15:0] sximm8;
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
   logic        err;
`endif

   regfile_seq_ctrl #(.DW(16), .RW(3)) dut (
      .clk(clk), .reset(reset), .load(load), .in(in), .s(s), .w(w),
      .readnum(readnum), .writenum(writenum), .write(write),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .aluop(aluop),
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
      .err(err),
`endif
      .sximm8(sximm8)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic la, lb, lc, ls, wr, as;
      logic [2:0] rn, wn;
      logic [1:0] vs, alu, sh;
      logic [15:0] imm;
   } ev_t;

   ev_t         exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] cur_ir   = 16'h0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Only fields meaningful in a given strobe cycle take part in the comparison.
   function automatic ev_t mk_ev(input logic la, lb, lc, ls, wr, as,
                                 input logic [2:0] rn, wn,
                                 input logic [1:0] vs, alu, sh,
                                 input logic [15:0] imm);
      ev_t e;
      e.la = la; e.lb = lb; e.lc = lc; e.ls = ls; e.wr = wr; e.as = as;
      e.rn  = (la | lb) ? rn : 3'd0;
      e.wn  = wr ? wn : 3'd0;
      e.vs  = wr ? vs : 2'd0;
      e.alu = lc ? alu : 2'd0;
      e.sh  = lc ? sh : 2'd0;
      e.imm = (wr && vs == 2'b01) ? imm : 16'h0;
      return e;
   endfunction

   // Reference model: expected strobe cycles and latency of one instruction.
   task automatic model(input logic [15:0] i, output int lat);
      logic [2:0]  opc, rn, rd, rm;
      logic [1:0]  op, sh;
      logic [15:0] imm;
      bit          mvn, cmp;
      opc = i[15:13]; op = i[12:11]; rn = i[10:8]; rd = i[7:5]; sh = i[4:3]; rm = i[2:0];
      imm = (i[7:0] >= 8'd128) ? (16'(i[7:0]) + 16'hFF00) : 16'(i[7:0]);
      if (opc == 3'd6 && op == 2'd2) begin
         exp_q.push_back(mk_ev(0,0,0,0,1,0, 0, rn, 2'b01, 0, 0, imm));
         lat = 3;
      end else if (opc == 3'd6 && op == 2'd0) begin
         exp_q.push_back(mk_ev(0,1,0,0,0,0, rm, 0, 0, 0, 0, 0));
         exp_q.push_back(mk_ev(0,0,1,0,0,1, 0, 0, 0, 2'd0, sh, 0));
         exp_q.push_back(mk_ev(0,0,0,0,1,0, 0, rd, 2'b00, 0, 0, 0));
         lat = 5;
      end else if (opc == 3'd5) begin
         mvn = (op == 2'd3);
         cmp = (op == 2'd1);
         if (!mvn) exp_q.push_back(mk_ev(1,0,0,0,0,0, rn, 0, 0, 0, 0, 0));
         exp_q.push_back(mk_ev(0,1,0,0,0,0, rm, 0, 0, 0, 0, 0));
         exp_q.push_back(mk_ev(0,0,1,cmp,0,mvn, 0, 0, 0, op, sh, 0));
         if (!cmp) exp_q.push_back(mk_ev(0,0,0,0,1,0, 0, rd, 2'b00, 0, 0, 0));
         lat = (mvn || cmp) ? 5 : 6;
      end else begin
         lat = 2;
      end
   endtask

   // Monitor: every cycle with a strobe must match the next expected event.
   always @(negedge clk) begin
      if (loada | loadb | loadc | write) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {loada, loadb, loadc, write}, 4'b0000);
         end else begin
            check("strobe_event",
                  mk_ev(loada, loadb, loadc, loads, write, asel, readnum, writenum,
                        vsel, aluop, shift, sximm8),
                  exp_q.pop_front());
         end
      end
   end

   task automatic run(input logic [15:0] instr, input bit do_load, input bit hold);
      int lat, n;
      n = 0;
      while (!w && n < 50) begin @(posedge clk); #1; n++; end
      check("idle_before_start", w, 1'b1);
      if (do_load) cur_ir = instr;
      load = do_load; in = instr; s = 1'b1;
      for (int r = 0; r < (hold ? 2 : 1); r++) begin
         model(cur_ir, lat);
         n = 0;
         do begin
            @(posedge clk); #1; n++;
            // load pulses while busy must not disturb IR.
            if (n == 1) begin load = 1'b1; in = 16'($urandom); end
            if (n == 2) load = 1'b0;
         end while (!w && n < 20);
         load = 1'b0;
         check("latency", n, lat);
      end
      s = 1'b0;
   endtask

   initial begin
      int          lat;
      logic [15:0] ri;
      reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_w", w, 1'b1);
      check("rst_strobes", {write, loada, loadb, loadc, loads, asel, bsel}, 7'b0);
      check("rst_vsel", vsel, 2'b00);
      check("rst_idx", {readnum, writenum}, 6'b0);
      check("rst_sximm8", sximm8, 16'h0000);

      run(16'hD007, 1, 0);   // MOV R0,#7
      run(16'hD180, 1, 0);   // MOV R1,#-128
      check("sximm8_neg", sximm8, 16'hFF80);
      run(16'hA140, 1, 0);   // ADD R2,R1,R0
      run(16'hA940, 1, 0);   // CMP R1,R0
      run(16'hC069, 1, 1);   // MOV R3,R1,LSL held: runs twice back-to-back
      run(16'h0000, 0, 0);   // re-runs IR without loading
      run(16'hB8E2, 1, 0);   // MVN
      run(16'h1234, 1, 0);   // illegal -> NOP (trap build aborts below)

      // Reset during GET_B of a MOV reg: only the operand fetch may appear.
      load = 1'b1; in = 16'hC069; s = 1'b1;
      exp_q.push_back(mk_ev(0,1,0,0,0,0, 3'd1, 0, 0, 0, 0, 0));
      @(posedge clk); #1 load = 1'b0; s = 1'b0;
      @(posedge clk);
      @(negedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("rstmid_w", w, 1'b1);
      check("rstmid_strobes", {write, loadc, loads}, 3'b000);
      @(posedge clk); #1;
      check("rstmid_no_write", write, 1'b0);
      cur_ir = 16'h0;

      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(3, 0))
            0: ri = {3'b110, 2'b10, 11'($urandom)};
            1: ri = {3'b110, 2'b00, 11'($urandom)};
            2: ri = {3'b101, 13'($urandom)};
            default: begin
`ifdef REGFILE_SEQ_ILLEGAL_TRAP_EN
               ri = {3'b101, 13'($urandom)};
`else
               ri = 16'($urandom);
`endif
            end
         endcase
         run(ri, ($urandom_range(3, 0) != 0), ($urandom_range(7, 0) == 0));
      end

      repeat (3) @(posedge clk);
      #1 check("queue_drained", exp_q.size(), 0);
      lat = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
Moore FSM that sequences the 8x16 register file and its surrounding datapath (A/B operand registers, shifter, ALU, C register, status register, writeback mux) to execute one 16-bit instruction at a time. It holds an instruction register. It decodes MOV and ALU instruction classes and drives the register-file controls (readnum, writenum, write) plus the datapath load and select strobes. A start/ready handshake (s/w) paces instructions from the testbench or a future fetch unit.

Parameters:
DW, 16, datapath and instruction width
RW, 3, register index width (8 registers)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load  input  1  capture in into the instruction register (IR) while w=1
in  input  DW  instruction word
s  input  1  start execution of the IR contents; sampled only while w=1
w  output  1  1 = idle in WAIT, ready for load/s
readnum  output  RW  register-file read index
writenum  output  RW  register-file write index
write  output  1  register-file write enable
loada, loadb, loadc, loads  output  1 each  datapath register load strobes
asel, bsel  output  1 each  asel=1 forces A operand to 0; bsel=1 selects sximm5 (tied 0 in this ISA subset)
vsel  output  2  writeback select: 00=C, 01=sximm8
shift  output  2  shifter op = IR[4:3]
aluop  output  2  ALU op = IR[12:11]
sximm8  output  DW  IR[7:0] sign-extended to DW

Behaviour:
- Reset is synchronous and active-high: at a clk edge with reset=1, state=WAIT and IR=0. Reset has priority over load and s.
- Outputs decode from the state register only. After the reset edge: w=1, all strobes 0, vsel=00, readnum=writenum=0, sximm8=0.
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- load=1 and w=1 at an edge: IR<=in. load is ignored while w=0.
- States:
  - WAIT: w=1. If s=1, go to DECODE.
  - DECODE: no strobes. Next state:
    - 110/10 (MOV imm) -> WRITE_IMM
    - 110/00 (MOV reg) -> GET_B
    - 101/xx (ADD, CMP, AND, MVN): op=11 (MVN) -> GET_B; otherwise -> GET_A
    - any other opcode -> WAIT (NOP)
  - WRITE_IMM: writenum=Rn, vsel=01, write=1 -> WAIT.
  - GET_A: readnum=Rn, loada=1 -> GET_B.
  - GET_B: readnum=Rm, loadb=1 -> ALU.
  - ALU: loadc=1; loads=1 only for CMP; asel=1 for MOV reg and MVN. Next: CMP -> WAIT; otherwise -> WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=00, write=1 -> WAIT.
- For MOV reg, aluop is forced to 00 (ADD) so that C = 0 + shifted Rm.
- Latency, counted as edges from s accepted until w=1 again:
  - MOV imm: 3
  - MOV reg: 5
  - MVN: 5
  - CMP: 5
  - ADD/AND: 6
  - illegal/NOP: 2
- s held high through completion: a new instruction starts on the first edge where w=1 and s=1. Back-to-back execution therefore re-runs the same IR unless load is used.
- load and s in the same WAIT cycle: the IR captures in, and DECODE in the next cycle uses the new IR.
- Reset mid-operation: the FSM aborts and returns to WAIT on that edge. No write strobe is issued in the following cycle.
- write is asserted for exactly one cycle per writing instruction.

Optional Feature:
- Macro: REGFILE_SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - An illegal opcode in DECODE moves to state TRAP. TRAP holds w=0 and err=1 until reset.
- Undefined:
  - The err port is absent.
  - Illegal opcodes return to WAIT as a NOP.

Decomposition:
- Package regfile_seq_pkg holds:
  - state enumeration
  - opcode constants (OPC_MOV=110, OPC_ALU=101)
  - op constants (MOV_IMM=10, MOV_REG=00, ALU_ADD=00, ALU_CMP=01, ALU_AND=10, ALU_MVN=11)
  - vsel encodings (VSEL_C=00, VSEL_IMM=01)
- One combinational sub-module, regfile_seq_decode: IR in; field slices, sximm8, and instruction-class flags out. The FSM stays in the top module.

Test Plan:
- Reset held 2 cycles, then released -> w=1, write=0, all strobes 0, sximm8=0x0000.
- load in=0xD007 (MOV R0,#7), then s=1 -> WRITE_IMM on the 2nd edge with writenum=0, vsel=01, write=1, sximm8=0x0007; w=1 after the 3rd edge.
- load in=0xD180 (MOV R1,#-128) -> sximm8=0xFF80, writenum=1.
- load in=0xA140 (ADD R2,R1,R0), s=1 -> expected strobe sequence:
  - GET_A: readnum=1, loada=1
  - GET_B: readnum=0, loadb=1
  - ALU: aluop=00, loadc=1
  - WRITE_REG: writenum=2, write=1
  - w=1 after 6 edges.
- load in=0xA940 (CMP R1,R0) -> ALU state has loads=1, loadc=1; write stays 0 throughout; w returns after 5 edges.
- load in=0xC069 (MOV R3,R1,LSL) -> sequence GET_B(readnum=1), ALU(asel=1, shift=01, aluop=00), WRITE_REG(writenum=3); w returns after 5 edges. Assert reset during GET_B of a repeat run -> WAIT next cycle, no write pulse.
